irda_tx_fifo: RTL and testbench
===============================

# irda_tx_fifo

Parametrised serial transmitter for the IR link. Accepts parallel words through a valid/ready handshake and buffers them in an internal FIFO. Serialises each word as an asynchronous frame: start bit, DATA_W data bits LSB first, optional parity, then 1 or 2 stop bits. It generalises the single-word, fixed-8N1 TX controller to configurable width, parity, stop bits, buffering and back-to-back frames. It sits between the switch/key front end and the IRDA_TXD pin.

## Interface
- CLK_HZ, 50_000_000, input clock frequency
- BAUD, 115_200, line rate; BIT_DIV = CLK_HZ/BAUD (integer, truncated, must be ≥ 16)
- DATA_W, 8, data bits per frame (5..9)
- PARITY_MODE, 0, 0 none / 1 even / 2 odd
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 4, word buffer depth (power of 2, ≥ 2)

- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- send_en  in  1  write valid
- Din  in  DATA_W  write data
- ready  out  1  FIFO not full; a write is accepted on an edge where send_en && ready
- busy  out  1  frame in progress
- fifo_level  out  $clog2(FIFO_DEPTH+1)  words buffered, excluding the word currently shifting
- Dout  out  1  serial line (drives IRDA_TXD)

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. Baud counter counts 0..BIT_DIV-1. Bit index counter counts 0..DATA_W-1 in DATA and 0..STOP_BITS-1 in STOP.
- IDLE: if the FIFO is non-empty, pop into the shift register, go to START, assert busy.
- START: line level is 0 for BIT_DIV cycles. DATA: each bit is held BIT_DIV cycles, LSB first. PARITY is skipped when PARITY_MODE=0. Even parity = XOR of data bits; odd parity = its inverse. STOP: line level is 1 for STOP_BITS×BIT_DIV cycles.
- At the end of the last stop bit:
  - FIFO non-empty: pop and enter START on the same edge. No idle cycle is inserted; busy stays 1.
  - FIFO empty: enter IDLE, busy falls to 0.
- ready = (fifo_level != FIFO_DEPTH), derived from registered level.
  - A push while full is ignored, even if a pop occurs on the same edge.
  - Push and pop on the same edge leave the level unchanged.
- Reset values: Dout idle level (1 NRZ, 0 IrDA), busy=0, ready=1, fifo_level=0, FSM=IDLE, counters 0.
- Reset mid-frame: the line returns to idle level on that edge. The frame is abandoned and the FIFO is flushed.
- Changes to send_en or Din while ready=0 have no effect.

## Timing
- Accept edge N: the word enters the FIFO. If IDLE and empty, it is popped at edge N+1 and the start bit is driven from N+1.
- Frame length = (1 + DATA_W + (PARITY_MODE!=0) + STOP_BITS) × BIT_DIV cycles.
- busy is high from the pop edge through the last stop-bit cycle.
- fifo_level updates on the edge after the push or pop.

## Configuration
- IRDA_PULSE_EN defined: Dout is IrDA SIR encoded.
  - Logical 0 (start bit, 0 data or parity bits): Dout=1 for PULSE_W = (BIT_DIV×3)/16 cycles at bit start, then 0.
  - Logical 1: Dout=0 for the whole bit. Idle level is 0.
- IRDA_PULSE_EN undefined: plain NRZ. Dout equals the logical bit value; idle level is 1.

## Structure
- Package irda_tx_pkg: the FSM state enum, PARITY_NONE/EVEN/ODD constants, and a bit-count helper function.
- Sub-module tx_fifo: synchronous FIFO with push/pop/level and a registered full flag.
- The top level holds the FSM, baud and bit counters, shift register, parity accumulator and output encoder.

## Test plan
All scenarios use CLK_HZ=50_000_000, BAUD=3_125_000 (BIT_DIV=16).
- Reset: hold reset 3 cycles -> Dout=1, busy=0, ready=1, fifo_level=0.
- 8N1, Din=8'hAC pulsed 1 cycle -> from the next edge Dout = 0 | 0,0,1,1,0,1,0,1 | 1, each bit 16 cycles. busy is high 160 cycles, then falls.
- Parity with 8'hAC: PARITY_MODE=1 -> parity bit 0; PARITY_MODE=2 -> parity bit 1. STOP_BITS=2 -> stop lasts 32 cycles.
- Overflow, FIFO_DEPTH=4, writes A..F on 6 consecutive cycles while idle:
  - A pops immediately; B..E are buffered.
  - ready=0 at F, so F is dropped.
  - Frames A..E go out back-to-back with no idle cycle between them.
- Reset asserted during data bit 3 -> Dout=1 on the next edge, busy=0, fifo_level=0. No further frames.
- IRDA_PULSE_EN defined, 8'hAC 8N1 -> 3-cycle high pulse at the start of the start bit and of each 0 bit. Dout=0 otherwise and after the frame.

Source files
------------

// File: rtl/irda_tx_fifo_pkg.sv
// Shared definitions for the IR-link serial transmitter.
//   tx_state_t       : frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   PARITY_*         : encodings of the PARITY_MODE parameter
//   cnt_bits()       : register width needed to count 0..n-1
package irda_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Width of a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irda_tx_fifo_tx_fifo.sv
// Synchronous word FIFO with a registered level and full flag.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (flushes contents)
//   push, wr_data   : write request and data; ignored while full
//   pop, rd_data    : read request and head-of-queue data (show-ahead)
//   full, empty     : status; full is a register, not decoded from level
//   level           : number of words stored
module tx_fifo
  import irda_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4   // power of 2, >= 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = cnt_bits(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_ALMOST = LVL_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10: begin
          level <= level + 1'b1;
          full  <= (level == LVL_ALMOST);
        end
        2'b01: begin
          level <= level - 1'b1;
          full  <= 1'b0;
        end
        default: ;  // idle, or push+pop: level unchanged
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and level define which
  // entries are valid, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/irda_tx_fifo.sv
// Buffered asynchronous-frame transmitter for the IR link (IRDA_TXD).
// Frame: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS
// stop bits; each bit lasts BIT_DIV = CLK_HZ/BAUD clocks. Buffered words go
// out back-to-back with no idle gap.
// Build option: define IRDA_PULSE_EN for IrDA SIR encoding (a 3/16-bit high
// pulse for each logical 0, idle low); otherwise Dout is plain NRZ, idle high.
// Ports:
//   CLOCK_50   : system clock, rising edge
//   reset      : synchronous active-high; abandons the frame, flushes FIFO
//   send_en    : write valid, accepted when ready is high
//   Din        : write data
//   ready      : FIFO not full
//   busy       : frame in progress
//   fifo_level : words buffered, excluding the word being shifted
//   Dout       : registered serial line output
module irda_tx_fifo
  import irda_tx_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic                            send_en,
  input  logic [DATA_W-1:0]               Din,
  output logic                            ready,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            Dout
);

  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int BAUD_W  = cnt_bits(BIT_DIV);
  localparam int IDX_W   = cnt_bits((DATA_W > STOP_BITS) ? DATA_W : STOP_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_DIV - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic              ODD_INV   = (PARITY_MODE == PARITY_ODD);
`ifdef IRDA_PULSE_EN
  localparam int                PULSE_W    = (BIT_DIV * 3) / 16;
  localparam logic [BAUD_W-1:0] PULSE_END  = BAUD_W'(PULSE_W);
  localparam logic              IDLE_LEVEL = 1'b0;
`else
  localparam logic              IDLE_LEVEL = 1'b1;
`endif

  tx_state_t         state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [IDX_W-1:0]  bit_idx, idx_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              par_acc, par_n;
  logic              bit_end;
  logic              load;
  logic              line_n;
  logic              dout_n;

  logic [DATA_W-1:0] fifo_data;
  logic              fifo_full;
  logic              fifo_empty;

  tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLOCK_50),
    .reset   (reset),
    .push    (send_en),
    .wr_data (Din),
    .pop     (load),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign ready   = !fifo_full;
  assign busy    = (state != IDLE);
  assign bit_end = (baud_cnt == BAUD_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    idx_n   = bit_idx;
    shift_n = shift;
    par_n   = par_acc;
    load    = 1'b0;
    baud_n  = (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;

    case (state)
      IDLE:  load = !fifo_empty;
      START: if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          par_n   = par_acc ^ shift[0];
          if (bit_idx == DATA_LAST) begin
            idx_n   = '0;
            state_n = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end else begin
            idx_n = bit_idx + 1'b1;
          end
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: begin
        if (bit_end) begin
          if (bit_idx == STOP_LAST) begin
            idx_n = '0;
            // Chain straight into the next frame when a word is waiting.
            if (fifo_empty) state_n = IDLE;
            else            load    = 1'b1;
          end else begin
            idx_n = bit_idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      state_n = START;
      shift_n = fifo_data;
      par_n   = 1'b0;
      idx_n   = '0;
    end

    // Logical level of the bit that will be on the line after this edge.
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift_n[0];
      PARITY:  line_n = par_n ^ ODD_INV;
      default: line_n = 1'b1;
    endcase

`ifdef IRDA_PULSE_EN
    dout_n = !line_n && (baud_n < PULSE_END);
`else
    dout_n = line_n;
`endif
  end

  // Dout is registered from next-state values so the pin is glitch-free and
  // still changes on the same edge as the FSM.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_acc  <= 1'b0;
      Dout     <= IDLE_LEVEL;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= idx_n;
      shift    <= shift_n;
      par_acc  <= par_n;
      Dout     <= dout_n;
    end
  end

endmodule

// File: tb/tb_irda_tx_fifo.sv
// Bench for irda_tx_fifo. Three instances share stimulus:
//   dut0 8N1, dut1 8E1, dut2 8O2; all BIT_DIV=16, FIFO_DEPTH=4.
// Honours IRDA_PULSE_EN in its expected line encoding.
module tb_irda_tx_fifo;

  localparam int BIT_DIV = 16;
  localparam int PULSE_W = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       send_en;
  logic [7:0] din;
  logic       dout  [3];
  logic       busy  [3];
  logic       ready [3];
  logic [2:0] level [3];

  always #10 clk = ~clk;

  irda_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(3_125_000), .DATA_W(8),
                 .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .CLOCK_50(clk), .reset(reset), .send_en(send_en), .Din(din),
    .ready(ready[0]), .busy(busy[0]), .fifo_level(level[0]), .Dout(dout[0]));

  irda_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(3_125_000), .DATA_W(8),
                 .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .CLOCK_50(clk), .reset(reset), .send_en(send_en), .Din(din),
    .ready(ready[1]), .busy(busy[1]), .fifo_level(level[1]), .Dout(dout[1]));

  irda_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(3_125_000), .DATA_W(8),
                 .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .CLOCK_50(clk), .reset(reset), .send_en(send_en), .Din(din),
    .ready(ready[2]), .busy(busy[2]), .fifo_level(level[2]), .Dout(dout[2]));

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] words [6];

  typedef struct {
    string      name;
    logic       send;
    logic [7:0] data;
    int         exp_level;
    int         exp_ready;
    int         exp_busy;
    logic       exp_line;   // logical bit expected on the line
    int         phase;      // cycle within that bit
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pin level for a logical bit at a given cycle within the bit.
  function automatic logic enc(input logic line, input int phase);
`ifdef IRDA_PULSE_EN
    return !line && (phase < PULSE_W);
`else
    return line;
`endif
  endfunction

  // Logical bit in a given bit slot of a frame; pm: 0 none, 1 even, 2 odd.
  function automatic logic exp_bit(input logic [7:0] d, input int pm, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (slot == 9 && pm != 0) return (^d) ^ (pm == 2);
    return 1'b1;
  endfunction

  function automatic int frame_len(input int d);
    int par_bits;
    int stop_bits;
    par_bits  = (d != 0) ? 1 : 0;
    stop_bits = (d == 2) ? 2 : 1;
    return (1 + 8 + par_bits + stop_bits) * BIT_DIV;
  endfunction

  // Sample at the current negedge for cycles t0..t0+ncyc-1 counted from the
  // first pop edge; words[0..nwords-1] are expected back-to-back, then idle.
  // Mismatching cycles are tallied per bit slot and checked once per slot.
  task automatic run_frames(input int t0, input int ncyc, input int nwords, input string tag);
    int bad_line [3];
    int bad_busy [3];
    for (int d = 0; d < 3; d++) begin
      bad_line[d] = 0;
      bad_busy[d] = 0;
    end
    for (int t = t0; t < t0 + ncyc; t++) begin
      for (int d = 0; d < 3; d++) begin
        int   flen;
        int   f;
        int   pos;
        logic ln;
        logic bz;
        flen = frame_len(d);
        f    = t / flen;
        pos  = t % flen;
        if (f < nwords) begin
          ln = exp_bit(words[f], d, pos / BIT_DIV);
          bz = 1'b1;
        end else begin
          ln = 1'b1;
          bz = 1'b0;
        end
        if (dout[d] !== enc(ln, pos % BIT_DIV)) bad_line[d]++;
        if (busy[d] !== bz) bad_busy[d]++;
      end
      if ((t % BIT_DIV == BIT_DIV - 1) || (t == t0 + ncyc - 1)) begin
        for (int d = 0; d < 3; d++) begin
          check($sformatf("%s dut%0d slot%0d Dout bad cycles", tag, d, t / BIT_DIV), bad_line[d], 0);
          check($sformatf("%s dut%0d slot%0d busy bad cycles", tag, d, t / BIT_DIV), bad_busy[d], 0);
          bad_line[d] = 0;
          bad_busy[d] = 0;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s dut%0d Dout", tag, d), int'(dout[d]), int'(enc(1'b1, 0)));
      check($sformatf("%s dut%0d busy", tag, d), int'(busy[d]), 0);
      check($sformatf("%s dut%0d ready", tag, d), int'(ready[d]), 1);
      check($sformatf("%s dut%0d level", tag, d), int'(level[d]), 0);
    end
  endtask

  initial begin
    // Overflow burst A..F on consecutive edges k0..k5, idle at k6.
    // A pops at k1 (start bit from k1); B..E fill the FIFO; F is dropped.
    vecs[0] = '{"ovf k0 push A", 1'b1, 8'hA1, 1, 1, 0, 1'b1, 0};
    vecs[1] = '{"ovf k1 push B", 1'b1, 8'hB2, 1, 1, 1, 1'b0, 0};
    vecs[2] = '{"ovf k2 push C", 1'b1, 8'hC3, 2, 1, 1, 1'b0, 1};
    vecs[3] = '{"ovf k3 push D", 1'b1, 8'hD4, 3, 1, 1, 1'b0, 2};
    vecs[4] = '{"ovf k4 push E", 1'b1, 8'hE5, 4, 0, 1, 1'b0, 3};
    vecs[5] = '{"ovf k5 push F", 1'b1, 8'hF6, 4, 0, 1, 1'b0, 4};
    vecs[6] = '{"ovf k6 no push", 1'b0, 8'h00, 4, 0, 1, 1'b0, 5};

    reset   = 1'b1;
    send_en = 1'b0;
    din     = 8'h00;

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Single word 8'hAC on all three formats.
    words[0] = 8'hAC;
    send_en  = 1'b1;
    din      = 8'hAC;
    @(posedge clk);
    @(negedge clk);
    send_en = 1'b0;
    din     = 8'h00;
    @(posedge clk);
    @(negedge clk);
    run_frames(0, 13 * BIT_DIV, 1, "ac");

    // Overflow burst, table driven on dut0.
    for (int i = 0; i < 7; i++) begin
      send_en = vecs[i].send;
      din     = vecs[i].data;
      @(posedge clk);
      @(negedge clk);
      check({vecs[i].name, " level"}, int'(level[0]), vecs[i].exp_level);
      check({vecs[i].name, " ready"}, int'(ready[0]), vecs[i].exp_ready);
      check({vecs[i].name, " busy"},  int'(busy[0]),  vecs[i].exp_busy);
      check({vecs[i].name, " Dout"},  int'(dout[0]),
            int'(enc(vecs[i].exp_line, vecs[i].phase)));
    end
    send_en = 1'b0;
    for (int i = 0; i < 6; i++) words[i] = vecs[i].data;
    // Five frames back-to-back from t=0 at k1; F must never appear.
    run_frames(5, 5 * frame_len(2) + 2 * BIT_DIV - 5, 5, "ovf");
    check_idle("after ovf");

    // Reset during data bit 3 with a second word still buffered.
    words[0] = 8'hAC;
    words[1] = 8'h5A;
    send_en  = 1'b1;
    din      = 8'hAC;
    @(posedge clk);
    @(negedge clk);
    din = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    send_en = 1'b0;
    din     = 8'h00;
    check("pre_rst dut0 level", int'(level[0]), 1);
    run_frames(0, 4 * BIT_DIV + 6, 2, "pre_rst");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("mid reset");
    reset = 1'b0;
    run_frames(0, 25 * BIT_DIV, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
